// File: rtl/orv64_param_pkg.sv
// rtl/orv64_param_pkg.sv - core-wide size parameters
package orv64_param_pkg;
    localparam int ORV64_PHY_ADDR_WIDTH = 56;
endpackage

// File: rtl/orv64_typedef_pkg.sv
// rtl/orv64_typedef_pkg.sv - shared physical address and PMP CSR types
package orv64_typedef_pkg;
    import orv64_param_pkg::*;

    typedef logic [ORV64_PHY_ADDR_WIDTH-1:0] orv64_paddr_t;

    typedef enum logic [1:0] {
        PMP_OFF   = 2'b00,
        PMP_TOR   = 2'b01,
        PMP_NA4   = 2'b10,
        PMP_NAPOT = 2'b11
    } orv64_pmp_addr_mode_t;

    // pmpaddr holds paddr[PAW-1:2]; upper bits of the 64-bit CSR are reserved
    typedef struct packed {
        logic [63-(ORV64_PHY_ADDR_WIDTH-2):0] rsvd;
        logic [ORV64_PHY_ADDR_WIDTH-3:0]      addr;
    } orv64_csr_pmpaddr_t;

    localparam int ORV64_NAPOT_KW = $clog2(ORV64_PHY_ADDR_WIDTH + 1);
endpackage

// File: rtl/orv64_napot_fmt.sv
// rtl/orv64_napot_fmt.sv - turns region size exponent and base into pmpaddr/mode
module orv64_napot_fmt
    import orv64_param_pkg::*;
    import orv64_typedef_pkg::*;
(
    input  logic [ORV64_NAPOT_KW-1:0] k_i,
    input  orv64_paddr_t              base_i,
    input  logic                      neg_i,
    input  logic                      bad_i,
    output orv64_csr_pmpaddr_t        pmpaddr_o,
    output orv64_pmp_addr_mode_t      mode_o,
    output logic                      err_o
);
    localparam int PAW = ORV64_PHY_ADDR_WIDTH;
    localparam int KW  = ORV64_NAPOT_KW;

    logic         err;
    orv64_paddr_t napot;

    always_comb begin
        err       = neg_i | bad_i | (k_i < KW'(2));
        napot     = base_i | ~({PAW{1'b1}} << (k_i - KW'(1)));
        pmpaddr_o = '0;
        mode_o    = PMP_OFF;
        if (!err) begin
            if (k_i == KW'(2)) begin
                mode_o         = PMP_NA4;
                pmpaddr_o.addr = base_i[PAW-1:2];
            end else if (k_i == KW'(PAW)) begin
                // whole space has no zero bit above the ones run
                mode_o         = PMP_NAPOT;
                pmpaddr_o.addr = '1;
            end else begin
                mode_o         = PMP_NAPOT;
                pmpaddr_o.addr = napot[PAW-1:2];
            end
        end
        err_o = err;
    end
endmodule

// File: rtl/orv64_napot_encode.sv
// rtl/orv64_napot_encode.sv - serial [base,bounds] to pmpaddr NA4/NAPOT encoder
module orv64_napot_encode
    import orv64_param_pkg::*;
    import orv64_typedef_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  orv64_paddr_t         req_base,
    input  orv64_paddr_t         req_bounds,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output orv64_csr_pmpaddr_t   rsp_pmpaddr,
    output orv64_pmp_addr_mode_t rsp_mode,
    output logic                 rsp_err
);
    localparam int PAW = ORV64_PHY_ADDR_WIDTH;
    localparam int KW  = ORV64_NAPOT_KW;

    typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DONE} state_e;

    state_e               state_q, state_d;
    orv64_paddr_t         base_q, base_d;
    orv64_paddr_t         size_m1_q, size_m1_d;
    logic                 neg_q, neg_d;
    logic                 ones_done_q, ones_done_d;
    logic                 bad_q, bad_d;
    logic [KW-1:0]        k_q, k_d;
    logic [KW-1:0]        idx_q, idx_d;
    logic                 rsp_valid_q, rsp_valid_d;
    orv64_csr_pmpaddr_t   rsp_pmpaddr_q, rsp_pmpaddr_d;
    orv64_pmp_addr_mode_t rsp_mode_q, rsp_mode_d;
    logic                 rsp_err_q, rsp_err_d;

    orv64_csr_pmpaddr_t   fmt_pmpaddr;
    orv64_pmp_addr_mode_t fmt_mode;
    logic                 fmt_err;
    logic [PAW:0]         diff;

    orv64_napot_fmt u_fmt (
        .k_i       (k_q),
        .base_i    (base_q),
        .neg_i     (neg_q),
        .bad_i     (bad_q),
        .pmpaddr_o (fmt_pmpaddr),
        .mode_o    (fmt_mode),
        .err_o     (fmt_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            base_q        <= '0;
            size_m1_q     <= '0;
            neg_q         <= 1'b0;
            ones_done_q   <= 1'b0;
            bad_q         <= 1'b0;
            k_q           <= '0;
            idx_q         <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_pmpaddr_q <= '0;
            rsp_mode_q    <= PMP_OFF;
            rsp_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            base_q        <= base_d;
            size_m1_q     <= size_m1_d;
            neg_q         <= neg_d;
            ones_done_q   <= ones_done_d;
            bad_q         <= bad_d;
            k_q           <= k_d;
            idx_q         <= idx_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_pmpaddr_q <= rsp_pmpaddr_d;
            rsp_mode_q    <= rsp_mode_d;
            rsp_err_q     <= rsp_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        size_m1_d     = size_m1_q;
        neg_d         = neg_q;
        ones_done_d   = ones_done_q;
        bad_d         = bad_q;
        k_d           = k_q;
        idx_d         = idx_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_pmpaddr_d = rsp_pmpaddr_q;
        rsp_mode_d    = rsp_mode_q;
        rsp_err_d     = rsp_err_q;
        diff          = {1'b0, req_bounds} - {1'b0, req_base};
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    base_d      = req_base;
                    size_m1_d   = diff[PAW-1:0];
                    neg_d       = diff[PAW];
                    ones_done_d = 1'b0;
                    bad_d       = 1'b0;
                    k_d         = '0;
                    idx_d       = '0;
                    state_d     = ST_SCAN;
                end
            end
            ST_SCAN: begin
                // trailing ones of size_m1 give k; any later one, or a base bit under the run, is an error
                if (!ones_done_q) begin
                    if (size_m1_q[idx_q]) begin
                        k_d = idx_q + KW'(1);
                        if (base_q[idx_q]) bad_d = 1'b1;
                    end else begin
                        ones_done_d = 1'b1;
                    end
                end else if (size_m1_q[idx_q]) begin
                    bad_d = 1'b1;
                end
                if (idx_q == KW'(PAW - 1)) state_d = ST_DONE;
                else                       idx_d   = idx_q + KW'(1);
            end
            ST_DONE: begin
                if (!rsp_valid_q) begin
                    rsp_valid_d   = 1'b1;
                    rsp_pmpaddr_d = fmt_pmpaddr;
                    rsp_mode_d    = fmt_mode;
                    rsp_err_d     = fmt_err;
                end else if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign req_ready   = (state_q == ST_IDLE);
    assign rsp_valid   = rsp_valid_q;
    assign rsp_pmpaddr = rsp_pmpaddr_q;
    assign rsp_mode    = rsp_mode_q;
    assign rsp_err     = rsp_err_q;
endmodule

// File: tb/tb_orv64_napot_encode.sv
// tb/tb_orv64_napot_encode.sv - directed and round-trip bench for orv64_napot_encode
module tb_orv64_napot_encode;
    import orv64_param_pkg::*;
    import orv64_typedef_pkg::*;

    localparam int PAW = ORV64_PHY_ADDR_WIDTH;
    localparam logic [63:0] PAW_MASK = (64'd1 << PAW) - 64'd1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 req_valid;
    logic                 req_ready;
    orv64_paddr_t         req_base;
    orv64_paddr_t         req_bounds;
    logic                 rsp_valid;
    logic                 rsp_ready;
    orv64_csr_pmpaddr_t   rsp_pmpaddr;
    orv64_pmp_addr_mode_t rsp_mode;
    logic                 rsp_err;

    int          n_checks = 0;
    int          n_fails  = 0;
    logic [63:0] r_addr;
    logic [1:0]  r_mode;
    logic        r_err;
    int          r_lat;

    always #5 clk = ~clk;

    orv64_napot_encode dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_base    (req_base),
        .req_bounds  (req_bounds),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_pmpaddr (rsp_pmpaddr),
        .rsp_mode    (rsp_mode),
        .rsp_err     (rsp_err)
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // independent NAPOT decoder model used for the round trip
    task automatic napot_dec(input logic [63:0] addr, output logic [63:0] b, output logic [63:0] e);
        int          t;
        logic [63:0] size;
        t = 0;
        while (t < PAW - 2 && addr[t]) t++;
        if (t >= PAW - 2) begin
            b = 64'd0;
            e = PAW_MASK;
        end else begin
            size = 64'd1 << (t + 3);
            b    = (addr << 2) & ~(size - 64'd1) & PAW_MASK;
            e    = b + size - 64'd1;
        end
    endtask

    task automatic send(input logic [63:0] base, input logic [63:0] bounds);
        int w;
        w = 0;
        @(negedge clk);
        while (!req_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        check_eq("req_ready_wait", {63'd0, req_ready}, 64'd1);
        req_base   = base[PAW-1:0];
        req_bounds = bounds[PAW-1:0];
        req_valid  = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        r_lat = 0;
        while (!rsp_valid && r_lat < 200) begin
            @(posedge clk);
            #1;
            r_lat++;
        end
        check_eq("rsp_timeout", {63'd0, rsp_valid}, 64'd1);
        r_addr = rsp_pmpaddr;
        r_mode = rsp_mode;
        r_err  = rsp_err;
    endtask

    task automatic ack();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic run(input string tag, input logic [63:0] base, input logic [63:0] bounds,
                       input logic [63:0] exp_addr, input logic [1:0] exp_mode, input logic exp_err);
        send(base, bounds);
        wait_rsp();
        check_eq({tag, "_lat"}, 64'(r_lat), 64'(PAW + 1));
        check_eq({tag, "_addr"}, r_addr, exp_addr);
        check_eq({tag, "_mode"}, {62'd0, r_mode}, {62'd0, exp_mode});
        check_eq({tag, "_err"}, {63'd0, r_err}, {63'd0, exp_err});
        ack();
    endtask

    initial begin
        logic [63:0] db, de, rb, size, base, bounds;
        logic        stable, seen;
        int          k;

        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; req_base = '0; req_bounds = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_req_ready", {63'd0, req_ready}, 64'd1);
        check_eq("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check_eq("rst_rsp_err", {63'd0, rsp_err}, 64'd0);
        check_eq("rst_rsp_mode", {62'd0, rsp_mode}, 64'd0);
        check_eq("rst_rsp_pmpaddr", rsp_pmpaddr, 64'd0);
        rst = 1'b0;

        run("napot64k", 64'h8000_0000, 64'h8000_FFFF, 64'h2000_1FFF, 2'b11, 1'b0);
        run("na4",      64'h1000, 64'h1003, 64'h400, 2'b10, 1'b0);
        run("napot8",   64'h1008, 64'h100F, 64'h402, 2'b11, 1'b0);
        run("misalign", 64'h1004, 64'h100B, 64'h0, 2'b00, 1'b1);
        run("nonpow2",  64'h0, 64'h17, 64'h0, 2'b00, 1'b1);
        run("negative", 64'h2000, 64'h1FFF, 64'h0, 2'b00, 1'b1);
        run("size2",    64'h10, 64'h11, 64'h0, 2'b00, 1'b1);
        run("size1",    64'h20, 64'h20, 64'h0, 2'b00, 1'b1);
        run("whole",    64'h0, PAW_MASK, 64'h003F_FFFF_FFFF_FFFF, 2'b11, 1'b0);
        napot_dec(r_addr, db, de);
        check_eq("whole_rt_base", db, 64'h0);
        check_eq("whole_rt_bounds", de, 64'h00FF_FFFF_FFFF_FFFF);

        // back-pressure: 16 KiB region at 0x4000
        send(64'h4000, 64'h7FFF);
        wait_rsp();
        stable = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (!rsp_valid || req_ready || rsp_pmpaddr != r_addr || rsp_mode != r_mode || rsp_err != r_err)
                stable = 1'b0;
        end
        check_eq("hold_stable", {63'd0, stable}, 64'd1);
        check_eq("hold_addr", r_addr, 64'h17FF);
        check_eq("hold_mode", {62'd0, r_mode}, 64'd3);
        ack();
        check_eq("ready_after_ack", {63'd0, req_ready}, 64'd1);

        // reset in the middle of the scan
        send(64'h1000, 64'h1003);
        repeat (20) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check_eq("midrst_req_ready", {63'd0, req_ready}, 64'd1);
        check_eq("midrst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        seen = 1'b0;
        repeat (70) begin
            @(posedge clk);
            #1;
            if (rsp_valid) seen = 1'b1;
        end
        check_eq("midrst_no_rsp", {63'd0, seen}, 64'd0);
        run("after_rst", 64'h1008, 64'h100F, 64'h402, 2'b11, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            k      = $urandom_range(3, PAW);
            size   = 64'd1 << k;
            rb     = {$urandom, $urandom};
            base   = rb & ~(size - 64'd1) & PAW_MASK;
            bounds = base + size - 64'd1;
            send(base, bounds);
            wait_rsp();
            napot_dec(r_addr, db, de);
            check_eq("rnd_err", {63'd0, r_err}, 64'd0);
            check_eq("rnd_mode", {62'd0, r_mode}, 64'd3);
            check_eq("rnd_base", db, base);
            check_eq("rnd_bounds", de, bounds);
            ack();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/orv64_napot_encode.md
Name: orv64_napot_encode

Overview:
- Inverse of the PMP NAPOT address decoder.
- Takes a physical region given as inclusive [base, bounds] and returns the pmpaddr value and pmpcfg A-field mode that encode that region: NA4 or NAPOT. If the region cannot be encoded, it flags an error.
- Used by the debug/boot PMP programming path and by the verification scoreboard to build pmpaddr CSR writes.
- Serial bit-scan engine with valid/ready request and response handshakes. Fixed latency.

Parameters:
- none. Widths come from ORV64_PHY_ADDR_WIDTH (PAW) in orv64_param_pkg.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request valid.
- req_ready  output  1  block can accept a request.
- req_base  input  orv64_paddr_t  first byte of the region.
- req_bounds  input  orv64_paddr_t  last byte of the region, inclusive.
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  consumer accepts the result.
- rsp_pmpaddr  output  orv64_csr_pmpaddr_t  encoded pmpaddr. The .addr field holds paddr[PAW-1:2].
- rsp_mode  output  orv64_pmp_addr_mode_t  PMP_NA4=2'b10 or PMP_NAPOT=2'b11. PMP_OFF when rsp_err=1.
- rsp_err  output  1  region cannot be encoded.

Behaviour:
- Reset values:
  - FSM goes to IDLE.
  - req_ready=1, rsp_valid=0, rsp_err=0, rsp_mode=PMP_OFF, rsp_pmpaddr='0.
  - Scan index=0.
- FSM has three states:
  - IDLE: req_ready=1. When req_valid&&req_ready:
    - latch base_q = req_base.
    - compute and latch size_m1_q = req_bounds - req_base at PAW+1 bits. The carry-out is latched as neg_q (bounds < base).
    - clear ones_done_q and bad_q, set k_q=0 and idx=0, go to SCAN.
  - SCAN: req_ready=0. Examines one bit idx per cycle, for idx = 0..PAW-1.
    - If !ones_done_q and size_m1_q[idx]=1:
      - k_q <= idx+1.
      - if base_q[idx]=1, set bad_q (misaligned).
    - If !ones_done_q and size_m1_q[idx]=0: set ones_done_q.
    - If ones_done_q and size_m1_q[idx]=1: set bad_q (size is not a power of two).
    - At idx=PAW-1, go to DONE.
  - DONE: drive the result registers.
    - rsp_valid=1. Hold all rsp_* stable until rsp_ready. On handshake, go to IDLE.
- Result, with size = 2^k and k = number of trailing ones in size_m1:
  - err = neg_q | bad_q | (k<2).
  - k==2: mode NA4, pmpaddr.addr = base_q[PAW-1:2].
  - k>=3: mode NAPOT, pmpaddr.addr = (base_q | ((1<<(k-1))-1))[PAW-1:2]. This gives k-3 trailing ones in .addr with a 0 above them.
  - k==PAW (whole space, base=0): mode NAPOT, pmpaddr.addr = all ones.
  - err=1: pmpaddr='0, mode=PMP_OFF.
- Latency: rsp_valid rises exactly PAW+1 cycles after the accepting edge, independent of data. There is no early abort.
- Only one request is in flight. req_ready=0 outside IDLE, so there are no simultaneous request and response events.
- Back-pressure: DONE may hold for any number of cycles. A new request can be accepted at the earliest one cycle after the rsp handshake.
- rst asserted in any state returns to IDLE on the next edge. Any in-flight request is discarded with no response.
- Round trip: for every err=0 result, feeding rsp_pmpaddr to orv64_napot_addr must return napot_base=req_base and napot_bounds=req_bounds. The exception is NA4, which the decoder does not handle.

Decomposition:
- orv64_typedef_pkg gets orv64_pmp_addr_mode_t, with PMP_OFF/TOR/NA4/NAPOT. Reuse it if it already exists.
- orv64_param_pkg supplies ORV64_PHY_ADDR_WIDTH.
- The result formatting (k, base, flags to pmpaddr and mode) is pure combinational logic. It is a natural sub-module, orv64_napot_fmt. The scan FSM stays in the top module.

Test Plan (PAW=56):
- base 0x8000_0000, bounds 0x8000_FFFF -> NAPOT, addr 0x2000_1FFF, err=0, rsp_valid exactly 57 cycles after accept.
- base 0x1000, bounds 0x1003 -> NA4, addr 0x400. base 0x1008, bounds 0x100F -> NAPOT, addr 0x402.
- base 0x1004, bounds 0x100B (misaligned) -> err. base 0x0, bounds 0x17 (size not a power of two) -> err. base 0x2000, bounds 0x1FFF (negative) -> err. base 0x10, bounds 0x11 (size 2) -> err. All error cases give mode=PMP_OFF, pmpaddr=0.
- base 0, bounds 2^56-1 -> NAPOT, addr all ones. Decoder round trip gives 0 and all ones.
- Hold rsp_ready=0 for 10 cycles -> rsp_* stable and req_ready=0. Pulse rst at SCAN idx 20 -> IDLE next cycle, no rsp_valid, the next request completes normally.
- 1000 random aligned power-of-two regions (k from 3 to 56) through the orv64_napot_addr round trip -> exact base and bounds match, err=0.
